// File: rtl/stream_fifo_source.sv
// Stream FIFO source: buffers read data in block RAM and replays it as length-bounded AXI-Stream transfers.
// Define STREAM_FIFO_SOURCE_TLAST_EN to drive m_axis_tlast on the final beat of each transfer.
module stream_fifo_source #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 512,
  parameter int DEPTH_BITS = 9
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  fifo_push,
  input  logic [DATA_WIDTH-1:0] data_to_fifo,
  output logic                  fifo_full,
  output logic                  fifo_overflow,
  output logic [DEPTH_BITS:0]   data_count,
  input  logic                  read_req,
  input  logic [8:0]            length,
  output logic                  busy,
  output logic                  transfer_done,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0001,
    S_WAIT      = 4'b0010,
    S_READ_DATA = 4'b0100,
    S_READ_DONE = 4'b1000
  } state_t;

  localparam logic [DEPTH_BITS:0]   FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS-1:0] LAST_ADDR  = DEPTH_BITS'(DEPTH - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [DEPTH_BITS:0]     count;
  logic                    overflow_reg;
  logic [8:0]              len_reg;
  logic [8:0]              pop_cnt;
  logic [8:0]              sent_cnt;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;

  logic full;
  logic empty;
  logic push_ok;
  logic out_free;
  logic pop;
  logic handshake;
  logic last_hs;
  logic [8:0] len_minus_one;

  assign full          = (count == FULL_COUNT);
  assign empty         = (count == '0);
  assign push_ok       = fifo_push && !full;
  assign len_minus_one = len_reg - 9'd1;

  // The output register refills in the same cycle it is drained, giving one beat per clock.
  assign out_free  = !out_valid || m_axis_tready;
  assign pop       = (state == S_READ_DATA) && out_free && !empty && (pop_cnt < len_reg);
  assign handshake = out_valid && m_axis_tready;
  assign last_hs   = handshake && (state == S_READ_DATA) && (sent_cnt == len_minus_one);

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_to_fifo;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + DEPTH_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + DEPTH_BITS'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (DEPTH_BITS + 1)'(1);
        2'b01:   count <= count - (DEPTH_BITS + 1)'(1);
        default: count <= count;
      endcase
      if (fifo_push && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Registered read port doubles as the AXI-Stream output stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= mem[rd_ptr];
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_FIFO_SOURCE_TLAST_EN
  logic out_last;
  logic pop_is_last;

  assign pop_is_last = (pop_cnt == len_minus_one);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_last <= 1'b0;
    end else if (pop) begin
      out_last <= pop_is_last;
    end else if (handshake) begin
      out_last <= 1'b0;
    end
  end

  assign m_axis_tlast = out_last;
`else
  assign m_axis_tlast = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      len_reg  <= '0;
      pop_cnt  <= '0;
      sent_cnt <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (read_req && (length != 9'd0)) begin
            state    <= S_WAIT;
            len_reg  <= length;
            pop_cnt  <= '0;
            sent_cnt <= '0;
            busy_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!empty) begin
            state <= S_READ_DATA;
          end
        end
        S_READ_DATA: begin
          if (pop) begin
            pop_cnt <= pop_cnt + 9'd1;
          end
          if (handshake) begin
            sent_cnt <= sent_cnt + 9'd1;
          end
          if (last_hs) begin
            state    <= S_READ_DONE;
            done_reg <= 1'b1;
          end
        end
        S_READ_DONE: begin
          state    <= S_IDLE;
          busy_reg <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_full     = full;
  assign fifo_overflow = overflow_reg;
  assign data_count    = count;
  assign busy          = busy_reg;
  assign transfer_done = done_reg;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;

endmodule

// File: tb/tb_stream_fifo_source.sv
// Directed bench for stream_fifo_source: cycle tables for short transfers plus hand sequences
// for overflow, FIFO underrun mid-transfer, ignored requests and asynchronous reset abort.
module tb_stream_fifo_source;

  localparam int DW = 128;

`ifdef STREAM_FIFO_SOURCE_TLAST_EN
  localparam int TL = 1;
`else
  localparam int TL = 0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          fifo_push = 1'b0;
  logic [DW-1:0] data_to_fifo = '0;
  logic          fifo_full;
  logic          fifo_overflow;
  logic [9:0]    data_count;
  logic          read_req = 1'b0;
  logic [8:0]    length = '0;
  logic          busy;
  logic          transfer_done;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  stream_fifo_source dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .fifo_push     (fifo_push),
    .data_to_fifo  (data_to_fifo),
    .fifo_full     (fifo_full),
    .fifo_overflow (fifo_overflow),
    .data_count    (data_count),
    .read_req      (read_req),
    .length        (length),
    .busy          (busy),
    .transfer_done (transfer_done),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] beats[$];
  bit            lasts[$];
  int            done_cnt;

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       req;
    logic [8:0] len;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_busy;
    logic       e_done;
    logic [9:0] e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int p, input int d, input int rq, input int ln, input int rd,
                              input int ev, input int ed, input int el, input int eb, input int edn,
                              input int ec);
    vec_t r;
    r.push = p[0];    r.data = 8'(d);    r.req = rq[0];    r.len = 9'(ln);  r.rdy = rd[0];
    r.e_valid = ev[0]; r.e_data = 8'(ed); r.e_last = el[0]; r.e_busy = eb[0];
    r.e_done = edn[0]; r.e_count = 10'(ec);
    return r;
  endfunction

  function automatic logic [DW-1:0] word(input int i);
    return {4{32'(i) ^ 32'h5A00_0000}};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts a transfer with tready held high and records every beat until busy falls.
  task automatic run_xfer(input logic [8:0] len, input bit poke);
    beats.delete();
    lasts.delete();
    done_cnt = 0;
    m_axis_tready = 1'b1;
    read_req = 1'b1;
    length = len;
    tick();
    read_req = 1'b0;
    length = '0;
    for (int i = 0; i < 2000; i++) begin
      if (m_axis_tvalid) begin
        beats.push_back(m_axis_tdata);
        lasts.push_back(m_axis_tlast);
      end
      if (transfer_done) done_cnt++;
      if (!busy) break;
      if (poke && i == 2) begin
        read_req = 1'b1;
        length = 9'd5;
      end else begin
        read_req = 1'b0;
        length = '0;
      end
      tick();
    end
    read_req = 1'b0;
    chk("xfer_idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int bad;
    int hs;
    logic [DW-1:0] act_data;
    logic [DW-1:0] exp_data;

    // Asynchronous reset and reset values
    #3 aresetn = 1'b0;
    tick();
    tick();
    chk("rst_full", 128'(fifo_full), 128'(0));
    chk("rst_overflow", 128'(fifo_overflow), 128'(0));
    chk("rst_count", 128'(data_count), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(transfer_done), 128'(0));
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
    chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
    aresetn = 1'b1;

    // Row n: expected outputs after edge n, inputs held during cycle n.
    // push 1..4, length 4, tready high: beats 3..6 cycles after read_req
    vecs.push_back(mk(1, 1, 0, 0, 1,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1,  0, 0, 0,  0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 0, 1,  0, 0, 0,  0, 0, 2));
    vecs.push_back(mk(1, 4, 0, 0, 1,  0, 0, 0,  0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 4, 1,  0, 0, 0,  0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 1, 0,  1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 2, 0,  1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 3, 0,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 4, TL, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0));
    // push 1..8, length 3, tready toggling: tdata holds while stalled, 5 words remain
    for (int k = 0; k < 8; k++) vecs.push_back(mk(1, k + 1, 0, 0, 1,  0, 0, 0, 0, 0, k));
    vecs.push_back(mk(0, 0, 1, 3, 1,  0, 0, 0,  0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  1, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  1, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0,  1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 1, 0,  1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 0,  1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 2, 0,  1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 3, TL, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 3, TL, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 5));

    foreach (vecs[n]) begin
      tick();
      act_data = m_axis_tvalid ? m_axis_tdata : '0;
      exp_data = vecs[n].e_valid ? DW'(vecs[n].e_data) : '0;
      checks++;
      if (m_axis_tvalid !== vecs[n].e_valid || m_axis_tlast !== vecs[n].e_last ||
          busy !== vecs[n].e_busy || transfer_done !== vecs[n].e_done ||
          data_count !== vecs[n].e_count || act_data !== exp_data || fifo_full !== 1'b0) begin
        failures++;
        $display("FAIL vec[%0d] actual valid=%0b data=%0h last=%0b busy=%0b done=%0b count=%0d full=%0b required valid=%0b data=%0h last=%0b busy=%0b done=%0b count=%0d full=0",
                 n, m_axis_tvalid, act_data, m_axis_tlast, busy, transfer_done, data_count, fifo_full,
                 vecs[n].e_valid, exp_data, vecs[n].e_last, vecs[n].e_busy, vecs[n].e_done, vecs[n].e_count);
      end
      fifo_push = vecs[n].push;
      data_to_fifo = DW'(vecs[n].data);
      read_req = vecs[n].req;
      length = vecs[n].len;
      m_axis_tready = vecs[n].rdy;
    end
    fifo_push = 1'b0;
    read_req = 1'b0;
    m_axis_tready = 1'b1;

    // length 0 is ignored
    read_req = 1'b1;
    length = 9'd0;
    tick();
    read_req = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (busy || m_axis_tvalid) bad++;
    end
    chk("len0_ignored", 128'(bad), 128'(0));
    chk("len0_count", 128'(data_count), 128'(5));

    // read_req while busy is ignored: exactly two beats, 4 then 5
    run_xfer(9'd2, 1'b1);
    chk("busyreq_beats", 128'(beats.size()), 128'(2));
    if (beats.size() == 2) begin
      chk("busyreq_beat0", beats[0], 128'(4));
      chk("busyreq_beat1", beats[1], 128'(5));
      chk("busyreq_last", 128'({lasts[0], lasts[1]}), 128'(TL));
    end
    chk("busyreq_done", 128'(done_cnt), 128'(1));
    bad = 0;
    repeat (5) begin
      tick();
      if (busy || m_axis_tvalid) bad++;
    end
    chk("busyreq_no_extra", 128'(bad), 128'(0));
    chk("busyreq_count", 128'(data_count), 128'(3));

    // drain 6..8 so the FIFO is empty
    run_xfer(9'd3, 1'b0);
    chk("drain_beats", 128'(beats.size()), 128'(3));
    for (int k = 0; k < 3 && k < beats.size(); k++) chk("drain_data", beats[k], 128'(k + 6));
    chk("drain_count", 128'(data_count), 128'(0));

    // underrun mid-transfer: length 2, words arrive 11 cycles apart
    read_req = 1'b1;
    length = 9'd2;
    tick();
    read_req = 1'b0;
    beats.delete();
    done_cnt = 0;
    bad = 0;
    hs = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_axis_tvalid) beats.push_back(m_axis_tdata);
      if (transfer_done) done_cnt++;
      if (!busy && done_cnt == 0) bad++;
      if (i == 10 && (m_axis_tvalid || !busy)) hs++;
      if (!busy && done_cnt != 0) break;
      fifo_push = (i == 3) || (i == 14);
      data_to_fifo = (i == 3) ? DW'(8'hA1) : DW'(8'hA2);
      tick();
    end
    fifo_push = 1'b0;
    chk("underrun_beats", 128'(beats.size()), 128'(2));
    if (beats.size() == 2) begin
      chk("underrun_beat0", beats[0], 128'(8'hA1));
      chk("underrun_beat1", beats[1], 128'(8'hA2));
    end
    chk("underrun_gap_idle", 128'(hs), 128'(0));
    chk("underrun_busy_held", 128'(bad), 128'(0));
    chk("underrun_done", 128'(done_cnt), 128'(1));
    chk("underrun_end_busy", 128'(busy), 128'(0));

    // fill to DEPTH, then overflow
    for (int i = 0; i < 512; i++) begin
      fifo_push = 1'b1;
      data_to_fifo = word(i);
      tick();
    end
    chk("fill_full", 128'(fifo_full), 128'(1));
    chk("fill_count", 128'(data_count), 128'(512));
    chk("fill_no_overflow", 128'(fifo_overflow), 128'(0));
    data_to_fifo = word(9999);
    tick();
    fifo_push = 1'b0;
    chk("ovf_flag", 128'(fifo_overflow), 128'(1));
    chk("ovf_count", 128'(data_count), 128'(512));
    run_xfer(9'd511, 1'b0);
    chk("big_beats", 128'(beats.size()), 128'(511));
    bad = 0;
    hs = 0;
    for (int k = 0; k < beats.size(); k++) begin
      if (beats[k] !== word(k)) bad++;
      if (lasts[k]) hs++;
    end
    chk("big_data_errors", 128'(bad), 128'(0));
    chk("big_tlast_count", 128'(hs), 128'(TL));
    chk("big_count", 128'(data_count), 128'(1));
    chk("big_not_full", 128'(fifo_full), 128'(0));
    run_xfer(9'd1, 1'b0);
    chk("tail_beats", 128'(beats.size()), 128'(1));
    if (beats.size() == 1) chk("tail_data", beats[0], word(511));
    chk("tail_count", 128'(data_count), 128'(0));
    chk("ovf_sticky", 128'(fifo_overflow), 128'(1));

    // asynchronous reset after 5 beats of a 16-beat transfer
    for (int i = 0; i < 16; i++) begin
      fifo_push = 1'b1;
      data_to_fifo = word(300 + i);
      tick();
    end
    fifo_push = 1'b0;
    read_req = 1'b1;
    length = 9'd16;
    tick();
    read_req = 1'b0;
    hs = 0;
    done_cnt = 0;
    for (int i = 0; i < 100 && hs < 5; i++) begin
      if (m_axis_tvalid) hs++;
      if (transfer_done) done_cnt++;
      tick();
    end
    chk("abort_beats_before", 128'(hs), 128'(5));
    #2 aresetn = 1'b0;
    #1;
    chk("abort_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_count", 128'(data_count), 128'(0));
    chk("abort_overflow", 128'(fifo_overflow), 128'(0));
    chk("abort_tdata", 128'(m_axis_tdata), 128'(0));
    chk("abort_done_before", 128'(done_cnt), 128'(0));
    tick();
    tick();
    aresetn = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (m_axis_tvalid || busy || transfer_done) bad++;
    end
    chk("abort_stays_idle", 128'(bad), 128'(0));
    for (int i = 0; i < 2; i++) begin
      fifo_push = 1'b1;
      data_to_fifo = word(700 + i);
      tick();
    end
    fifo_push = 1'b0;
    run_xfer(9'd2, 1'b0);
    chk("post_abort_beats", 128'(beats.size()), 128'(2));
    for (int k = 0; k < 2 && k < beats.size(); k++) chk("post_abort_data", beats[k], word(700 + k));
    chk("post_abort_done", 128'(done_cnt), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
